// File: rtl/cdp1802_loader.sv
// Host-side boot/debug controller for the cdp1802: parses a byte-stream command
// protocol, owns program RAM while the CPU is held in reset, and releases it on GO.
module cdp1802_loader #(
  parameter logic [7:0] CMD_LOAD    = 8'h4C,
  parameter logic [7:0] CMD_PEEK    = 8'h50,
  parameter logic [7:0] CMD_GO      = 8'h47,
  parameter logic [7:0] CMD_HALT    = 8'h48,
  parameter bit         BOOT_HALTED = 1'b1
) (
  input  logic        clock,
  input  logic        resetq,
  input  logic        host_valid,
  input  logic [7:0]  host_data,
  output logic        host_ready,
  output logic        resp_valid,
  output logic [7:0]  resp_data,
  input  logic        resp_ready,
  output logic        cpu_resetq,
  output logic        running,
  output logic        err,
  input  logic        cpu_ram_rd,
  input  logic        cpu_ram_wr,
  input  logic [15:0] cpu_ram_a,
  input  logic [7:0]  cpu_ram_d,
  output logic        ram_rd,
  output logic        ram_wr,
  output logic [15:0] ram_a,
  output logic [7:0]  ram_d,
  input  logic [7:0]  ram_q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN,
    S_DATA,
    S_PEEK_RD,
    S_RESP
  } state_t;

  state_t      state;
  logic [15:0] addr;
  logic [8:0]  cnt;
  logic        peek;
  logic        loader_wr;
  logic        loader_rd;

  assign host_ready = (state != S_PEEK_RD) && (state != S_RESP);
  assign running    = cpu_resetq;

  // Loader strobes: a DATA write happens in the same clock as the byte handshake.
  assign loader_wr = (state == S_DATA) && host_valid;
  assign loader_rd = (state == S_PEEK_RD);

  always_ff @(posedge clock or negedge resetq) begin
    if (!resetq) begin
      state      <= S_IDLE;
      cpu_resetq <= ~BOOT_HALTED;
      err        <= 1'b0;
      resp_valid <= 1'b0;
      addr       <= 16'h0000;
      cnt        <= 9'd0;
      peek       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (host_valid) begin
            case (host_data)
              CMD_LOAD: begin
                if (!cpu_resetq) begin
                  state <= S_ADDR_HI;
                  peek  <= 1'b0;
                end else begin
                  err <= 1'b1;
                end
              end
              CMD_PEEK: begin
                if (!cpu_resetq) begin
                  state <= S_ADDR_HI;
                  peek  <= 1'b1;
                end else begin
                  err <= 1'b1;
                end
              end
              CMD_GO: begin
                cpu_resetq <= 1'b1;
                err        <= 1'b0;
              end
              CMD_HALT: cpu_resetq <= 1'b0;
              default:  err <= 1'b1;
            endcase
          end
        end
        S_ADDR_HI: begin
          if (host_valid) begin
            addr[15:8] <= host_data;
            state      <= S_ADDR_LO;
          end
        end
        S_ADDR_LO: begin
          if (host_valid) begin
            addr[7:0] <= host_data;
            state     <= peek ? S_PEEK_RD : S_LEN;
          end
        end
        S_LEN: begin
          if (host_valid) begin
            // A zero length byte means a full 256-byte block.
            cnt   <= (host_data == 8'h00) ? 9'd256 : {1'b0, host_data};
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (host_valid) begin
            addr <= addr + 16'd1;
            cnt  <= cnt - 9'd1;
            if (cnt == 9'd1) state <= S_IDLE;
          end
        end
        S_PEEK_RD: state <= S_RESP;
        S_RESP: begin
          // First RESP clock latches the synchronous RAM output; then wait for the host.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (state == S_RESP && !resp_valid) resp_data <= ram_q;
  end

  // Port ownership follows cpu_resetq; all strobes are forced low during reset.
  always_comb begin
    ram_rd = 1'b0;
    ram_wr = 1'b0;
    ram_a  = addr;
    ram_d  = host_data;
    if (cpu_resetq) begin
      ram_rd = resetq & cpu_ram_rd;
      ram_wr = resetq & cpu_ram_wr;
      ram_a  = cpu_ram_a;
      ram_d  = cpu_ram_d;
    end else begin
      ram_rd = resetq & loader_rd;
      ram_wr = resetq & loader_wr;
    end
  end

endmodule

// File: tb/tb_cdp1802_loader.sv
// Directed self-checking bench for cdp1802_loader with a behavioural synchronous RAM.
module tb_cdp1802_loader;

  logic        clock = 1'b0;
  logic        resetq;
  logic        host_valid;
  logic [7:0]  host_data;
  logic        host_ready;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic        resp_ready;
  logic        cpu_resetq;
  logic        running;
  logic        err;
  logic        cpu_ram_rd;
  logic        cpu_ram_wr;
  logic [15:0] cpu_ram_a;
  logic [7:0]  cpu_ram_d;
  logic        ram_rd;
  logic        ram_wr;
  logic [15:0] ram_a;
  logic [7:0]  ram_d;
  logic [7:0]  ram_q;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:65535];
  logic [23:0] wlog[$];

  cdp1802_loader dut (
    .clock      (clock),
    .resetq     (resetq),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .cpu_resetq (cpu_resetq),
    .running    (running),
    .err        (err),
    .cpu_ram_rd (cpu_ram_rd),
    .cpu_ram_wr (cpu_ram_wr),
    .cpu_ram_a  (cpu_ram_a),
    .cpu_ram_d  (cpu_ram_d),
    .ram_rd     (ram_rd),
    .ram_wr     (ram_wr),
    .ram_a      (ram_a),
    .ram_d      (ram_d),
    .ram_q      (ram_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wr) mem[ram_a] <= ram_d;
    if (ram_rd) ram_q <= mem[ram_a];
  end

  always @(negedge clock) begin
    if (ram_wr) wlog.push_back({ram_a, ram_d});
  end

  task automatic send(input logic [7:0] b);
    host_valid = 1'b1;
    host_data  = b;
    @(posedge clock);
    #1;
    host_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic peek_read(input logic [15:0] a, output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = 8'h00;
    send(8'h50);
    send(a[15:8]);
    send(a[7:0]);
    resp_ready = 1'b1;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(posedge clock);
      #1;
      if (resp_valid) begin
        ok = 1'b1;
        d  = resp_data;
      end
    end
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    resetq = 1'b0;
    host_valid = 1'b0;
    host_data = 8'h00;
    resp_ready = 1'b0;
    cpu_ram_rd = 1'b1;
    cpu_ram_wr = 1'b1;
    cpu_ram_a = 16'h0000;
    cpu_ram_d = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (cpu_resetq !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL reset_cpu: cpu_resetq=%b running=%b expected 0", cpu_resetq, running);
    end
    checks++;
    if (host_ready !== 1'b1 || err !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: ready=%b err=%b resp_valid=%b expected 1/0/0", host_ready, err, resp_valid);
    end
    checks++;
    if (ram_rd !== 1'b0 || ram_wr !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: rd=%b wr=%b expected 0/0", ram_rd, ram_wr);
    end
    cpu_ram_rd = 1'b0;
    cpu_ram_wr = 1'b0;
    resetq = 1'b1;
    idle(1);
  endtask

  task automatic test_load;
    logic [23:0] exp [3];
    exp[0] = 24'h0100AA; exp[1] = 24'h0101BB; exp[2] = 24'h0102CC;
    wlog.delete();
    send(8'h4C); send(8'h01); send(8'h00); send(8'h03);
    send(8'hAA); send(8'hBB); send(8'hCC);
    checks++;
    if (wlog.size() !== 3) begin
      errors++; $display("FAIL load_count: got %0d writes expected 3", wlog.size());
    end
    for (int i = 0; i < 3 && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i] !== exp[i]) begin
        errors++; $display("FAIL load_write%0d: got %h expected %h", i, wlog[i], exp[i]);
      end
    end
    checks++;
    if (host_ready !== 1'b1 || cpu_resetq !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL load_after: ready=%b cpu_resetq=%b err=%b expected 1/0/0", host_ready, cpu_resetq, err);
    end
  endtask

  task automatic test_wrap_gaps;
    wlog.delete();
    send(8'h4C); idle(2); send(8'hFF); idle(1); send(8'hFF); idle(3);
    send(8'h02); idle(2); send(8'h11); idle(4); send(8'h22);
    checks++;
    if (wlog.size() !== 2) begin
      errors++; $display("FAIL wrap_count: got %0d writes expected 2", wlog.size());
    end else begin
      checks++;
      if (wlog[0] !== 24'hFFFF11 || wlog[1] !== 24'h000022) begin
        errors++; $display("FAIL wrap_data: got %h %h expected ffff11 000022", wlog[0], wlog[1]);
      end
    end
  endtask

  task automatic test_len256;
    logic [7:0] d;
    bit ok;
    wlog.delete();
    send(8'h4C); send(8'h20); send(8'h00); send(8'h00);
    for (int i = 0; i < 256; i++) send(8'(i ^ 8'h5C));
    checks++;
    if (wlog.size() !== 256) begin
      errors++; $display("FAIL len256_count: got %0d writes expected 256", wlog.size());
    end else begin
      checks++;
      if (wlog[0] !== 24'h20005C || wlog[255] !== 24'h20FFA3) begin
        errors++; $display("FAIL len256_ends: got %h %h expected 20005c 20ffa3", wlog[0], wlog[255]);
      end
    end
    // Next byte must be parsed as an opcode: PEEK 2005 returns 05^5C = 59.
    peek_read(16'h2005, d, ok);
    checks++;
    if (!ok || d !== 8'h59 || wlog.size() !== 256 || err !== 1'b0) begin
      errors++; $display("FAIL len256_opcode: ok=%b data=%h writes=%0d err=%b expected 1/59/256/0", ok, d, wlog.size(), err);
    end
  endtask

  task automatic test_peek_stall;
    bit seen;
    send(8'h4C); send(8'h01); send(8'h00); send(8'h01); send(8'h5A);
    send(8'h50); send(8'h01); send(8'h00);
    checks++;
    if (ram_rd !== 1'b1 || ram_a !== 16'h0100 || host_ready !== 1'b0) begin
      errors++; $display("FAIL peek_rd: rd=%b a=%h ready=%b expected 1/0100/0", ram_rd, ram_a, host_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(posedge clock);
      #1;
      seen = resp_valid;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL peek_timeout: resp_valid=%b expected 1", resp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 8'h5A || host_ready !== 1'b0) begin
        errors++; $display("FAIL peek_hold%0d: valid=%b data=%h ready=%b expected 1/5a/0", i, resp_valid, resp_data, host_ready);
      end
      @(posedge clock);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || host_ready !== 1'b1) begin
      errors++; $display("FAIL peek_done: valid=%b ready=%b expected 0/1", resp_valid, host_ready);
    end
  endtask

  task automatic test_go_halt;
    send(8'h47);
    checks++;
    if (cpu_resetq !== 1'b1 || running !== 1'b1) begin
      errors++; $display("FAIL go_run: cpu_resetq=%b running=%b expected 1/1", cpu_resetq, running);
    end
    cpu_ram_wr = 1'b1; cpu_ram_a = 16'h1234; cpu_ram_d = 8'h77;
    #1;
    checks++;
    if (ram_wr !== 1'b1 || ram_rd !== 1'b0 || ram_a !== 16'h1234 || ram_d !== 8'h77) begin
      errors++; $display("FAIL go_mux: wr=%b rd=%b a=%h d=%h expected 1/0/1234/77", ram_wr, ram_rd, ram_a, ram_d);
    end
    cpu_ram_wr = 1'b0;
    @(posedge clock);
    #1;
    wlog.delete();
    send(8'h4C); send(8'h01);
    checks++;
    if (err !== 1'b1 || wlog.size() !== 0 || host_ready !== 1'b1) begin
      errors++; $display("FAIL run_load: err=%b writes=%0d ready=%b expected 1/0/1", err, wlog.size(), host_ready);
    end
    send(8'h48);
    checks++;
    if (cpu_resetq !== 1'b0 || err !== 1'b1) begin
      errors++; $display("FAIL halt: cpu_resetq=%b err=%b expected 0/1", cpu_resetq, err);
    end
    send(8'h47);
    checks++;
    if (err !== 1'b0 || cpu_resetq !== 1'b1) begin
      errors++; $display("FAIL go_clear: err=%b cpu_resetq=%b expected 0/1", err, cpu_resetq);
    end
    send(8'h00);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL unknown_op: err=%b expected 1", err);
    end
    send(8'h48);
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    bit ok;
    send(8'h4C); send(8'h30); send(8'h00); send(8'h05); send(8'h01); send(8'h02);
    resetq = 1'b0;
    #2;
    checks++;
    if (host_ready !== 1'b1 || err !== 1'b0 || cpu_resetq !== 1'b0) begin
      errors++; $display("FAIL mid_reset: ready=%b err=%b cpu_resetq=%b expected 1/0/0", host_ready, err, cpu_resetq);
    end
    idle(1);
    resetq = 1'b1;
    idle(1);
    peek_read(16'h3001, d, ok);
    checks++;
    if (!ok || d !== 8'h02) begin
      errors++; $display("FAIL mid_partial: ok=%b data=%h expected 1/02", ok, d);
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_wrap_gaps;
    test_len256;
    test_peek_stall;
    test_go_halt;
    test_reset_midframe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
